branch_redirect_unit: RTL and testbench



---
 rtl/branch_redirect_unit.sv | 133 +++++++++++++
 tb/tb_branch_redirect_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_unit.sv
// Branch redirect unit: resolves one branch request at a time and owns the fetch PC.
// A taken branch redirects the PC and holds the front end in flush for FLUSH_CYCLES cycles.
module branch_redirect_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_PC     = '0,
  parameter int               FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_op,
  input  logic [WIDTH-1:0] br_a,
  input  logic [WIDTH-1:0] br_b,
  input  logic [WIDTH-1:0] br_pc,
  input  logic [WIDTH-1:0] br_imm,
  output logic [WIDTH-1:0] pc,
  output logic             resolved,
  output logic             taken,
  output logic             flush
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EVAL  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam int               CW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_RSVD = 3'b010;
  localparam logic [2:0] OP_JUMP = 3'b011;
  localparam logic [2:0] OP_BLT  = 3'b100;
  localparam logic [2:0] OP_BGE  = 3'b101;
  localparam logic [2:0] OP_BLTU = 3'b110;
  localparam logic [2:0] OP_BGEU = 3'b111;

  logic [1:0]       state;
  logic [CW-1:0]    flush_cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] bpc_q;
  logic [WIDTH-1:0] imm_q;

  logic [WIDTH:0]   diff;
  logic             eq;
  logic             lt;
  logic             ltu;
  logic             cond;
  logic [WIDTH-1:0] target;

  assign br_ready = (state == IDLE);

  // One subtractor serves all compares; the sign-mismatch path keeps signed lt overflow-safe.
  assign diff   = {1'b0, a_q} - {1'b0, b_q};
  assign eq     = ~|diff[WIDTH-1:0];
  assign ltu    = diff[WIDTH];
  assign lt     = (a_q[WIDTH-1] != b_q[WIDTH-1]) ? a_q[WIDTH-1] : diff[WIDTH-1];
  assign target = (bpc_q + imm_q) & ALIGN_MASK;

  always_comb begin
    cond = 1'b0;
    case (op_q)
      OP_BEQ:  cond = eq;
      OP_BNE:  cond = !eq;
      OP_RSVD: cond = 1'b0;
      OP_JUMP: cond = 1'b1;
      OP_BLT:  cond = lt;
      OP_BGE:  cond = !lt;
      OP_BLTU: cond = ltu;
      OP_BGEU: cond = !ltu;
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      resolved  <= 1'b0;
      taken     <= 1'b0;
      flush     <= 1'b0;
      flush_cnt <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      bpc_q     <= '0;
      imm_q     <= '0;
    end else begin
      resolved <= 1'b0;
      taken    <= 1'b0;
      case (state)
        IDLE: begin
          if (!stall) pc <= pc + WIDTH'(4);
          if (br_valid && br_ready) begin
            op_q  <= br_op;
            a_q   <= br_a;
            b_q   <= br_b;
            bpc_q <= br_pc;
            imm_q <= br_imm;
            state <= EVAL;
          end
        end
        EVAL: begin
          resolved <= 1'b1;
          if (cond) begin
            taken     <= 1'b1;
            pc        <= target;
            flush     <= 1'b1;
            flush_cnt <= CW'(FLUSH_CYCLES - 1);
            state     <= FLUSH;
          end else begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          // Counter was preloaded so flush spans FLUSH_CYCLES cycles including the redirect cycle.
          if (flush_cnt == '0) begin
            flush <= 1'b0;
            state <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Scoreboard bench for branch_redirect_unit: a busy-window/PC reference model predicts
// every resolution and the per-cycle pc, br_ready and flush values.
module tb_branch_redirect_unit;

  localparam int          FC       = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_op;
  logic [31:0] br_a;
  logic [31:0] br_b;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic [31:0] pc;
  logic        resolved;
  logic        taken;
  logic        flush;

  branch_redirect_unit #(
    .WIDTH       (32),
    .RESET_PC    (RESET_PC),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall   (stall),
    .br_valid(br_valid),
    .br_ready(br_ready),
    .br_op   (br_op),
    .br_a    (br_a),
    .br_b    (br_b),
    .br_pc   (br_pc),
    .br_imm  (br_imm),
    .pc      (pc),
    .resolved(resolved),
    .taken   (taken),
    .flush   (flush)
  );

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [32:0] exp_q[$];
  logic [31:0] pc_m;
  bit          pend;
  bit          tk_m;
  logic [31:0] tgt_m;
  int          flush_left;
  int          acc_cnt = 0;
  bit          rand_stall = 0;
  logic [31:0] last_res_pc = '0;
  logic        last_res_taken = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit refTaken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return 1'b0;
      3'd3: return 1'b1;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      default: return a >= b;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic noteFail(input string name);
    chk_cnt++;
    $display("[TB] FAIL %s: got timeout expected event at %0t", name, $time);
  endtask

  // Reference model: the unit is busy for one evaluation cycle plus FC flush cycles when taken.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pc_m = RESET_PC;
        pend = 0;
        tk_m = 0;
        tgt_m = '0;
        flush_left = 0;
        exp_q.delete();
      end else if (pend) begin
        pend = 0;
        if (tk_m) begin
          pc_m = tgt_m;
          flush_left = FC;
        end
      end else if (flush_left > 0) begin
        flush_left--;
      end else begin
        if (!stall) pc_m = pc_m + 32'd4;
        if (br_valid) begin
          tk_m  = refTaken(br_op, br_a, br_b);
          tgt_m = (br_pc + br_imm) & 32'hFFFF_FFFC;
          pend  = 1;
          acc_cnt++;
          exp_q.push_back({tk_m, tk_m ? tgt_m : pc_m});
        end
      end
    end
  end

  // Monitor: per-cycle state checks plus scoreboard pop on each resolution pulse.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checkOutput("pc", pc, pc_m);
        checkOutput("br_ready", 32'(br_ready), 32'(!pend && flush_left == 0));
        checkOutput("flush", 32'(flush), 32'(flush_left > 0));
        if (resolved) begin
          if (exp_q.size() == 0) begin
            checkOutput("resolved_unexpected", 32'(resolved), 32'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("res_taken", 32'(taken), 32'(e[32]));
            checkOutput("res_pc", pc, e[31:0]);
            last_res_pc    = pc;
            last_res_taken = taken;
          end
        end else begin
          checkOutput("taken_without_resolved", 32'(taken), 32'd0);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_stall) stall = ($urandom_range(0, 3) == 0);
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] bpc, input logic [31:0] imm);
    int  start;
    bit  got;
    start    = acc_cnt;
    got      = 0;
    br_op    = op;
    br_a     = a;
    br_b     = b;
    br_pc    = bpc;
    br_imm   = imm;
    br_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (acc_cnt != start) begin
        got = 1;
        break;
      end
    end
    if (!got) noteFail("accept_timeout");
  endtask

  task automatic waitIdle();
    bit idle;
    idle     = 0;
    br_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!pend && flush_left == 0) begin
        idle = 1;
        break;
      end
    end
    if (!idle) noteFail("idle_timeout");
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          mode;
    bit          got;
    rst_n    = 1'b1;
    stall    = 1'b0;
    br_valid = 1'b0;
    br_op    = '0;
    br_a     = '0;
    br_b     = '0;
    br_pc    = '0;
    br_imm   = '0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_pc", pc, RESET_PC);
    checkOutput("reset_ready", 32'(br_ready), 32'd1);
    checkOutput("reset_resolved", 32'(resolved), 32'd0);
    checkOutput("reset_taken", 32'(taken), 32'd0);
    checkOutput("reset_flush", 32'(flush), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(3'd4, 32'hFFFF_FFF6, 32'd8, 32'h40, 32'h20);
    waitIdle();
    checkOutput("blt_neg_taken", 32'(last_res_taken), 32'd1);
    checkOutput("blt_neg_pc", last_res_pc, 32'h60);

    applyStimulus(3'd4, 32'h8000_0000, 32'd1, 32'h80, 32'h100);
    waitIdle();
    checkOutput("blt_ovf_taken", 32'(last_res_taken), 32'd1);
    applyStimulus(3'd6, 32'h8000_0000, 32'd1, 32'h80, 32'h100);
    waitIdle();
    checkOutput("bltu_ovf_taken", 32'(last_res_taken), 32'd0);

    // BNE follows BEQ with br_valid held high through EVAL and FLUSH.
    applyStimulus(3'd0, 32'h1234, 32'h1234, 32'h100, 32'hFFFF_FFF8);
    applyStimulus(3'd1, 32'h1234, 32'h1234, 32'h100, 32'hFFFF_FFF8);
    waitIdle();
    checkOutput("bne_eq_taken", 32'(last_res_taken), 32'd0);

    stall = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(3'd2, 32'd5, 32'd5, 32'h300, 32'h40);
    waitIdle();
    checkOutput("reserved_taken", 32'(last_res_taken), 32'd0);

    applyStimulus(3'd3, 32'd0, 32'd0, 32'hFFFF_FFF8, 32'd4);
    waitIdle();
    checkOutput("wrap_hold_pc", pc, 32'hFFFF_FFFC);
    stall = 1'b0;
    @(negedge clk);
    checkOutput("wrap_pc", pc, 32'h0);
    applyStimulus(3'd3, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h13);
    waitIdle();
    checkOutput("jump_wrap_pc", last_res_pc, 32'h0);

    applyStimulus(3'd3, 32'd0, 32'd0, 32'h200, 32'h10);
    br_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      if (flush_left > 0) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got) noteFail("flush_timeout");
    #3 rst_n = 1'b0;
    #1;
    checkOutput("midflush_reset_pc", pc, RESET_PC);
    checkOutput("midflush_reset_flush", 32'(flush), 32'd0);
    checkOutput("midflush_reset_ready", 32'(br_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("post_reset_pc0", pc, 32'd0);
    @(negedge clk);
    checkOutput("post_reset_pc4", pc, 32'd4);
    @(negedge clk);
    checkOutput("post_reset_pc8", pc, 32'd8);

    rand_stall = 1;
    for (int n = 0; n < 150; n++) begin
      op   = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 3);
      a    = $urandom;
      b    = $urandom;
      if (mode == 1) b = a;
      if (mode == 2) begin
        a = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
        b = 32'($urandom_range(0, 3));
      end
      if (mode == 3) b = a + 32'($urandom_range(0, 2)) - 32'd1;
      applyStimulus(op, a, b, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) waitIdle();
    end
    rand_stall = 0;
    stall = 1'b0;
    waitIdle();
    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
